// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory with streaming loader.
//   ld_state_e     : loader FSM states (idle, loading, completion pulse)
//   DefaultNopWord : default word returned at reset and on a faulting fetch
//   decode_pc()    : splits a byte PC into a word index and a fault flag
package instr_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } ld_state_e;

  localparam logic [31:0] DefaultNopWord = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] idx;
    logic        fault;
  } pc_decode_t;

  // addr_w is the word-address width; the PC is zero-extended to 64 bits by the caller.
  function automatic pc_decode_t decode_pc(input logic [63:0] pc, input int unsigned addr_w);
    pc_decode_t  d;
    logic [63:0] mask;
    mask    = (64'd1 << addr_w) - 64'd1;
    d.idx   = 32'((pc >> 2) & mask);
    d.fault = (pc[1:0] != 2'b00) || ((pc >> (addr_w + 32'd2)) != 64'd0);
    return d;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Load-channel and fetch-port bundle of the instruction memory.
//   master : boot loader / IF stage side (drives requests, observes status)
//   slave  : instr_mem_loader side
interface instr_mem_loader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned PC_W   = 32
) ();

  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;

  logic              fetch_en;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              fetch_fault;

  modport master (
    output load_start, load_base, load_len, load_valid, load_data, fetch_en, pc,
    input  load_ready, load_busy, load_done, instr_out, instr_valid, fetch_fault
  );

  modport slave (
    input  load_start, load_base, load_len, load_valid, load_data, fetch_en, pc,
    output load_ready, load_busy, load_done, instr_out, instr_valid, fetch_fault
  );

endinterface

// File: rtl/instr_mem_array.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Storage is never reset.
//   clk_i   : clock
//   we_i    : write enable, waddr_i/wdata_i
//   re_i    : read enable; rdata_o updates on the next edge and holds otherwise
module instr_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a built-in streaming loader.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : load channel (start/base/len, valid/ready/data, busy/done) and
//                fetch port (fetch_en/pc -> instr_out/instr_valid/fetch_fault)
// A burst writes load_len words from load_base upward with wrap-around. Fetches
// have one cycle of latency and are blocked while the loader is busy, so reads
// and writes never target the array in the same cycle.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 11,
  parameter int unsigned       PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DefaultNopWord)
) (
  input logic               clk,
  input logic               rst_n,
  instr_mem_loader_if.slave bus
);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              load_ready_q;
  logic              load_busy_q;
  logic              load_done_q;

  logic              instr_valid_q;
  logic              fetch_fault_q;
  // Masks the RAM read register: set at reset and after a faulting fetch.
  logic              out_nop_q;

  pc_decode_t        pc_dec;
  logic              accept;
  logic              fetch_go;
  logic              mem_re;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    pc_dec   = decode_pc(64'(bus.pc), ADDR_W);
    accept   = load_ready_q && bus.load_valid;
    fetch_go = bus.fetch_en && !load_busy_q;
    mem_re   = fetch_go && !pc_dec.fault;
  end

  // Loader FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      remaining_q  <= '0;
      load_ready_q <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.load_start) begin
            load_busy_q <= 1'b1;
            wr_ptr_q    <= bus.load_base;
            remaining_q <= bus.load_len;
            if (bus.load_len != '0) begin
              state_q      <= StLoad;
              load_ready_q <= 1'b1;
            end else begin
              state_q     <= StDone;
              load_done_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
            remaining_q <= remaining_q - (ADDR_W + 1)'(1);
            if (remaining_q == (ADDR_W + 1)'(1)) begin
              state_q      <= StDone;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          load_done_q <= 1'b0;
          load_busy_q <= 1'b0;
        end
        default: begin
          state_q      <= StIdle;
          load_ready_q <= 1'b0;
          load_busy_q  <= 1'b0;
          load_done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch status; data itself lives in the RAM's read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      out_nop_q     <= 1'b1;
    end else if (fetch_go) begin
      instr_valid_q <= 1'b1;
      fetch_fault_q <= pc_dec.fault;
      out_nop_q     <= pc_dec.fault;
    end else begin
      instr_valid_q <= 1'b0;
    end
  end

  instr_mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i  (clk),
    .we_i   (accept),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.load_data),
    .re_i   (mem_re),
    .raddr_i(ADDR_W'(pc_dec.idx)),
    .rdata_o(rd_data)
  );

  assign bus.load_ready  = load_ready_q;
  assign bus.load_busy   = load_busy_q;
  assign bus.load_done   = load_done_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_fault = fetch_fault_q;
  assign bus.instr_out   = out_nop_q ? NOP_WORD : rd_data;

endmodule
